// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES round engine.
//   - FSM state encoding
//   - legal round counts (10/12/14) and a legality check
//   - GF(2^8) helpers: xtime, gf_mul, gf_inv (multiplicative inverse, 0 -> 0)
package aes_pkg;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_e;

    function automatic bit nr_is_legal(input int unsigned nr);
        return (nr == NR_AES128) || (nr == NR_AES192) || (nr == NR_AES256);
    endfunction

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // b^254 = b^(2+4+...+128); maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = b;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_sub_bytes.sv
// aes_sub_bytes: 16-byte forward / inverse S-box substitution (combinational).
// Ports:
//   i_inv    - 0 = SubBytes, 1 = InvSubBytes
//   i_data   - 128-bit state in
//   o_data_c - 128-bit substituted state (combinational)
module aes_sub_bytes
    import aes_pkg::*;
(
    input  logic         i_inv,
    input  logic [127:0] i_data,
    output logic [127:0] o_data_c
);

    // Inverse followed by the affine transform
    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine transform followed by the inverse
    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    always_comb begin
        o_data_c = '0;
        for (int i = 0; i < 16; i++) begin
            o_data_c[8*i +: 8] = i_inv ? sbox_inv(i_data[8*i +: 8])
                                       : sbox_fwd(i_data[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encrypt/decrypt, one round per clock.
// Key schedule is external: rk_idx selects a round key, rk_data returns it
// combinationally in the same cycle.
// Ports:
//   clk, reset_n          - clock, async active-low reset
//   in_valid/in_ready     - input block handshake (in_ready only in IDLE)
//   in_mode               - 0 encrypt, 1 decrypt (latched on accept)
//   in_data               - input block, byte 0 in [127:120], column-major
//   rk_idx / rk_data      - round-key request / response
//   out_valid/out_ready   - result handshake; out_data held while waiting
//   out_data              - result block
//   abort                 - only when AES_ABORT_EN is defined: drop current block
// Parameter NR: 10, 12 or 14 rounds.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
`ifdef AES_ABORT_EN
    ,
    input  logic         abort
`endif
);

    if (!nr_is_legal(NR)) begin : g_nr_check
        $error("aes_round_engine: NR=%0d illegal, must be 10, 12 or 14", NR);
    end

    localparam logic [3:0] NR_IDX = 4'(NR);

    // Byte (row r, column c) lives at index r + 4c, MSB first
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int           src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*src) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        logic [7:0]   m0, m1, m2, m3;
        o = '0;
        // Circulant coefficients: forward {02,03,01,01}, inverse {0e,0b,0d,09}
        m0 = inv ? 8'h0e : 8'h02;
        m1 = inv ? 8'h0b : 8'h03;
        m2 = inv ? 8'h0d : 8'h01;
        m3 = inv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127 - 32*c -: 32];
            o[127 - 32*c -: 32] = {
                gf_mul(a0, m0) ^ gf_mul(a1, m1) ^ gf_mul(a2, m2) ^ gf_mul(a3, m3),
                gf_mul(a0, m3) ^ gf_mul(a1, m0) ^ gf_mul(a2, m1) ^ gf_mul(a3, m2),
                gf_mul(a0, m2) ^ gf_mul(a1, m3) ^ gf_mul(a2, m0) ^ gf_mul(a3, m1),
                gf_mul(a0, m1) ^ gf_mul(a1, m2) ^ gf_mul(a2, m3) ^ gf_mul(a3, m0)};
        end
        return o;
    endfunction

    aes_state_e   r_fsm,       w_fsm_nxt;
    logic [3:0]   r_round,     w_round_nxt;
    logic [127:0] r_data,      w_data_nxt;
    logic         r_mode,      w_mode_nxt;
    logic [127:0] r_out_data,  w_out_data_nxt;
    logic         r_out_valid, w_out_valid_nxt;

    logic         w_idle_open;
    logic         w_accept;
    logic         w_last;
    logic [127:0] w_sb_in, w_sb, w_enc_sr, w_enc, w_dec_ark, w_dec, w_round_out;

`ifdef AES_ABORT_EN
    assign w_idle_open = (r_fsm == ST_IDLE) && !abort;
`else
    assign w_idle_open = (r_fsm == ST_IDLE);
`endif
    assign w_accept  = in_valid && w_idle_open;
    assign in_ready  = w_idle_open;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Round datapath; byte substitution commutes with row shifts, so one
    // S-box bank serves both directions (InvShiftRows moved before it)
    assign w_last    = (r_round == NR_IDX);
    assign w_sb_in   = r_mode ? shift_rows(r_data, 1'b1) : r_data;

    aes_sub_bytes u_sub_bytes (
        .i_inv    (r_mode),
        .i_data   (w_sb_in),
        .o_data_c (w_sb)
    );

    assign w_enc_sr    = shift_rows(w_sb, 1'b0);
    assign w_enc       = (w_last ? w_enc_sr : mix_columns(w_enc_sr, 1'b0)) ^ rk_data;
    assign w_dec_ark   = w_sb ^ rk_data;
    assign w_dec       = w_last ? w_dec_ark : mix_columns(w_dec_ark, 1'b1);
    assign w_round_out = r_mode ? w_dec : w_enc;

    // Round-key request: initial key on accept, then per-round key
    always_comb begin
        rk_idx = 4'd0;
        case (r_fsm)
            ST_IDLE:  rk_idx = in_mode ? NR_IDX : 4'd0;
            ST_ROUND: rk_idx = r_mode ? (NR_IDX - r_round) : r_round;
            default:  rk_idx = 4'd0;
        endcase
    end

    // Next-state and datapath updates
    always_comb begin
        w_fsm_nxt       = r_fsm;
        w_round_nxt     = r_round;
        w_data_nxt      = r_data;
        w_mode_nxt      = r_mode;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        case (r_fsm)
            ST_IDLE: begin
                if (w_accept) begin
                    w_data_nxt  = in_data ^ rk_data;
                    w_round_nxt = 4'd1;
                    w_mode_nxt  = in_mode;
                    w_fsm_nxt   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_data_nxt  = w_round_out;
                w_round_nxt = r_round + 4'd1;
                if (w_last) begin
                    w_out_data_nxt  = w_round_out;
                    w_out_valid_nxt = 1'b1;
                    w_round_nxt     = 4'd0;
                    w_fsm_nxt       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_fsm_nxt       = ST_IDLE;
                end
            end
            default: w_fsm_nxt = ST_IDLE;
        endcase
`ifdef AES_ABORT_EN
        // Abort wins over completion and out_ready; result register untouched
        if (abort && (r_fsm != ST_IDLE)) begin
            w_fsm_nxt       = ST_IDLE;
            w_round_nxt     = 4'd0;
            w_out_data_nxt  = r_out_data;
            w_out_valid_nxt = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm       <= ST_IDLE;
            r_round     <= 4'd0;
            r_data      <= '0;
            r_mode      <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_round     <= w_round_nxt;
            r_data      <= w_data_nxt;
            r_mode      <= w_mode_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine: NR=10 and NR=14 instances, round keys
// from an in-bench key expansion (S-box built by the generator-3 walk).
module tb_aes_round_engine;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         in_valid_a, in_ready_a, in_mode_a, out_valid_a, out_ready_a;
    logic [127:0] in_data_a, rk_data_a, out_data_a;
    logic [3:0]   rk_idx_a;
    logic         in_valid_b, in_ready_b, in_mode_b, out_valid_b, out_ready_b;
    logic [127:0] in_data_b, rk_data_b, out_data_b;
    logic [3:0]   rk_idx_b;
`ifdef AES_ABORT_EN
    logic         abort_a, abort_b;
`endif

    logic [7:0]   sbox [0:255];
    logic [127:0] rk10 [0:15];
    logic [127:0] rk14 [0:15];

    int checks = 0;
    int errors = 0;

    assign rk_data_a = rk10[rk_idx_a];
    assign rk_data_b = rk14[rk_idx_b];

    aes_round_engine #(.NR(10)) u_dut10 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_mode   (in_mode_a),
        .in_data   (in_data_a),
        .rk_idx    (rk_idx_a),
        .rk_data   (rk_data_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_data  (out_data_a)
`ifdef AES_ABORT_EN
        ,
        .abort     (abort_a)
`endif
    );

    aes_round_engine #(.NR(14)) u_dut14 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_mode   (in_mode_b),
        .in_data   (in_data_b),
        .rk_idx    (rk_idx_b),
        .rk_data   (rk_data_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_data  (out_data_b)
`ifdef AES_ABORT_EN
        ,
        .abort     (abort_b)
`endif
    );

    function automatic logic [7:0] bxtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Walk p over powers of 3 and q over powers of 1/3, so q = p^-1
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        sbox[0] = 8'h63;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end
    endtask

    task automatic expand_key(input int nk, input logic [255:0] key, input bit is14);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nr;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if ((i % nk) == 0) begin
                t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = bxtime(rcon);
            end else if ((nk > 6) && ((i % nk) == 4)) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++) begin
            if (is14) rk14[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
            else      rk10[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block to the NR=10 engine from IDLE and follow it to DONE
    task automatic run10(input logic mode, input logic [127:0] din,
                         input logic [127:0] exp, input string tag);
        in_valid_a = 1'b1;
        in_mode_a  = mode;
        in_data_a  = din;
        #1;
        chk({tag, "_idle_ready"}, 128'(in_ready_a), 128'(1));
        chk({tag, "_idle_rk"}, 128'(rk_idx_a), mode ? 128'(10) : 128'(0));
        tick();
        in_valid_a = 1'b0;
        in_data_a  = {4{$urandom}};
        for (int j = 0; j < 10; j++) begin
            chk({tag, "_busy_valid"}, 128'(out_valid_a), 128'(0));
            chk({tag, "_round_rk"}, 128'(rk_idx_a), mode ? 128'(9 - j) : 128'(j + 1));
            tick();
        end
        chk({tag, "_latency_valid"}, 128'(out_valid_a), 128'(1));
        chk({tag, "_data"}, out_data_a, exp);
        chk({tag, "_done_ready"}, 128'(in_ready_a), 128'(0));
    endtask

    task automatic release10(input string tag);
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        chk({tag, "_rel_valid"}, 128'(out_valid_a), 128'(0));
        chk({tag, "_rel_ready"}, 128'(in_ready_a), 128'(1));
    endtask

    initial begin
        logic seen;
        reset_n     = 1'b0;
        in_valid_a  = 1'b0; in_mode_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
        in_valid_b  = 1'b0; in_mode_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
`ifdef AES_ABORT_EN
        abort_a = 1'b0;
        abort_b = 1'b0;
`endif
        for (int k = 0; k < 16; k++) begin
            rk10[k] = '0;
            rk14[k] = '0;
        end
        build_sbox();
        expand_key(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
        expand_key(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1);

        // Reset state
        tick();
        chk("rst_out_valid", 128'(out_valid_a), 128'(0));
        chk("rst_out_data", out_data_a, 128'h0);
        chk("rst_in_ready", 128'(in_ready_a), 128'(1));
        chk("rst_rk_enc", 128'(rk_idx_a), 128'(0));
        in_mode_a = 1'b1;
        #1;
        chk("rst_rk_dec", 128'(rk_idx_a), 128'(10));
        in_mode_a = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // NR=10 encrypt and decrypt
        run10(1'b0, PT, CT, "enc10");
        release10("enc10");
        run10(1'b1, CT, PT, "dec10");
        release10("dec10");

        // NR=14 encrypt
        in_valid_b = 1'b1;
        in_mode_b  = 1'b0;
        in_data_b  = PT;
        #1;
        chk("enc14_idle_rk", 128'(rk_idx_b), 128'(0));
        tick();
        in_valid_b = 1'b0;
        for (int j = 0; j < 14; j++) begin
            chk("enc14_busy_valid", 128'(out_valid_b), 128'(0));
            chk("enc14_round_rk", 128'(rk_idx_b), 128'(j + 1));
            tick();
        end
        chk("enc14_latency_valid", 128'(out_valid_b), 128'(1));
        chk("enc14_data", out_data_b, CT2);
        out_ready_b = 1'b1;
        tick();
        out_ready_b = 1'b0;
        chk("enc14_rel_valid", 128'(out_valid_b), 128'(0));

        // Back-pressure in DONE with in_valid noise
        run10(1'b0, PT, CT, "stall");
        for (int k = 0; k < 5; k++) begin
            in_valid_a = ((k % 2) == 0);
            in_mode_a  = ((k % 2) == 1);
            in_data_a  = {4{$urandom}};
            tick();
            chk("stall_valid", 128'(out_valid_a), 128'(1));
            chk("stall_data", out_data_a, CT);
            chk("stall_ready", 128'(in_ready_a), 128'(0));
        end
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        in_mode_a   = 1'b1;
        in_data_a   = CT;
        tick();
        out_ready_a = 1'b0;
        chk("stall_rel_valid", 128'(out_valid_a), 128'(0));
        chk("stall_no_accept_ready", 128'(in_ready_a), 128'(1));
        chk("stall_no_accept_rk", 128'(rk_idx_a), 128'(10));
        run10(1'b1, CT, PT, "after_stall");
        release10("after_stall");

        // Reset in the middle of round 4
        in_valid_a = 1'b1;
        in_mode_a  = 1'b0;
        in_data_a  = PT;
        tick();
        in_valid_a = 1'b0;
        repeat (3) tick();
        chk("midrst_round4_rk", 128'(rk_idx_a), 128'(4));
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 128'(out_valid_a), 128'(0));
        chk("midrst_ready", 128'(in_ready_a), 128'(1));
        chk("midrst_data", out_data_a, 128'h0);
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen = seen | out_valid_a;
        end
        chk("midrst_no_output", 128'(seen), 128'(0));
        run10(1'b0, PT, CT, "post_rst");
        release10("post_rst");

`ifdef AES_ABORT_EN
        // Abort in IDLE blocks accept
        abort_a    = 1'b1;
        in_valid_a = 1'b1;
        in_mode_a  = 1'b0;
        in_data_a  = PT;
        #1;
        chk("abort_idle_ready", 128'(in_ready_a), 128'(0));
        tick();
        abort_a    = 1'b0;
        in_valid_a = 1'b0;
        #1;
        chk("abort_idle_no_accept", 128'(in_ready_a), 128'(1));
        chk("abort_idle_rk", 128'(rk_idx_a), 128'(0));
        // Abort at round 6
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        repeat (5) tick();
        chk("abort_round6_rk", 128'(rk_idx_a), 128'(6));
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        #1;
        chk("abort_valid", 128'(out_valid_a), 128'(0));
        chk("abort_ready", 128'(in_ready_a), 128'(1));
        chk("abort_data_kept", out_data_a, CT);
        run10(1'b0, PT, CT, "after_abort");
        release10("after_abort");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_engine.md
AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

Interface
REQ-001 SHALL have parameter NR, default 10, meaning number of cipher rounds; legal values 10, 12 and 14 (AES-128, AES-192 and AES-256).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  input block offered.
REQ-005 SHALL have port in_ready  output  1  engine accepts a block this cycle.
REQ-006 SHALL have port in_mode  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
REQ-007 SHALL have port in_data  input  128  plaintext or ciphertext, byte 0 in [127:120], column-major.
REQ-008 SHALL have port rk_idx  output  4  round-key index requested this cycle.
REQ-009 SHALL have port rk_data  input  128  round key for rk_idx, valid in the same cycle (combinational lookup, external key store).
REQ-010 SHALL have port out_valid  output  1  result block held.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port out_data  output  128  result block.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in ROUND and DONE it SHALL be 0.
REQ-015 Accept SHALL occur when in_valid && in_ready; on accept, state_reg <= in_data ^ rk_data, round counter <= 1, mode latched, FSM -> ROUND.
REQ-016 In IDLE, rk_idx SHALL be 0 when in_mode=0 and NR when in_mode=1.
REQ-017 In ROUND with counter r (1..NR), rk_idx SHALL be r for encrypt and NR-r for decrypt.
REQ-018 An encrypt round SHALL be SubBytes, ShiftRows, MixColumns and AddRoundKey, with MixColumns omitted when r==NR.
REQ-019 A decrypt round SHALL be InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns, with InvMixColumns omitted when r==NR.
REQ-020 Each round SHALL take one cycle; when r==NR, the round result SHALL load out_data, out_valid SHALL become 1 and FSM -> DONE.
REQ-021 Latency from the accept edge to out_valid high SHALL be exactly NR cycles.
REQ-022 In DONE, out_data and out_valid SHALL hold until out_ready=1; on that edge out_valid <= 0 and FSM -> IDLE.
REQ-023 A new block SHALL NOT be accepted in the out_ready cycle; the earliest next accept is the following cycle.
REQ-024 in_valid, in_data and in_mode SHALL be ignored outside IDLE.
REQ-025 out_data SHALL change only on the final-round edge.

Reset
REQ-026 While reset_n=0: FSM=IDLE, counter=0, state_reg=0, out_data=0, out_valid=0, latched mode=0.
REQ-027 Reset asserted mid-operation SHALL discard the block with no output; after release the FSM is IDLE with in_ready=1.

Configuration
REQ-028 Macro AES_ABORT_EN SHALL, when defined, add input port abort (1 bit) as the last port.
REQ-029 With AES_ABORT_EN, abort=1 in ROUND or DONE SHALL return the FSM to IDLE on the next edge with out_valid=0; abort SHALL take priority over round completion and out_ready.
REQ-030 With AES_ABORT_EN, abort=1 in IDLE SHALL block accept in that cycle.
REQ-031 Without AES_ABORT_EN, the abort port and its logic SHALL be absent and behaviour SHALL be REQ-013..027 only.

Structure
REQ-032 Shared package aes_pkg SHALL hold the FSM state enum, the NR legality constants, and the GF(2^8) xtime/mul functions used by (Inv)MixColumns.
REQ-033 Sub-module aes_sub_bytes (128-bit, inv select input) SHALL provide forward/inverse S-box substitution; ShiftRows and MixColumns stay in aes_round_engine.
REQ-034 An illegal NR SHALL cause an elaboration-time error.

Verification
REQ-035 The bench SHALL cover these scenarios, with round keys supplied from a reference key schedule:
- NR=10, encrypt, FIPS-197 C.1 key 000102..0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
- NR=10, decrypt of 69c4e0d86a7b0430d8cdb78070b4c55a with the same key -> 00112233445566778899aabbccddeeff; rk_idx sequence 10,9,...,0.
- NR=14, encrypt, key 000102..1f, same pt -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- out_ready held 0 for 5 cycles in DONE -> out_data/out_valid stable, in_ready=0, in_valid pulses ignored; accept possible the cycle after out_ready=1.
- reset_n pulsed low at round 4 -> out_valid never rises for that block; the next block gives the correct result.
- AES_ABORT_EN defined, abort at round 6 -> IDLE next edge, out_valid stays 0; a back-to-back block then completes correctly.
